// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read port, burst command and downstream stream signals
// seen by fifo_stream_reader. The master modport is the reader's view; the
// slave modport is the view of the FIFO/command/consumer side.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              empty;
    logic              rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CNT_W-1:0]  rd_count;

    modport master (
        input  start, len, empty, fifo_dout, m_ready,
        output busy, done, rd_en, m_data, m_valid, rd_count
    );

    modport slave (
        output start, len, empty, fifo_dout, m_ready,
        input  busy, done, rd_en, m_data, m_valid, rd_count
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side master for a small synchronous FIFO with one-cycle read latency.
// Pops a programmed number of words and forwards them on a valid/ready stream
// through a 2-entry skid buffer so a stalled consumer never loses data.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing pops while words remain, FIFO non-empty and skid has room
// DRAIN | all pops issued; waiting for in-flight and buffered words to leave
// DONE  | one-cycle completion pulse
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    fifo_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [LEN_W-1:0]  remaining;
    logic              inflight;
    logic [1:0]        occ;
    logic [1:0]        occ_nx;
    logic [1:0]        pending;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              m_valid_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  rd_count_q;
    logic              hs;
    logic              credit;
    logic              rd_en_c;

    // Handshake, skid credit and pop request, all from registered state.
    // pending counts words that will occupy the skid: buffered plus in flight.
    always_comb begin
        hs      = (occ != 2'd0) && bus.m_ready;
        pending = occ + {1'b0, inflight};
        credit  = (pending <= 2'd1) || ((pending == 2'd2) && hs);
        rd_en_c = (state == RUN) && !bus.empty && (remaining != '0) && credit;
        occ_nx  = occ + {1'b0, inflight} - {1'b0, hs};
    end

    // Next-state logic; DRAIN exits as soon as the skid will be empty after this edge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_en_c && (remaining == LEN_W'(1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_nx == 2'd0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Burst counter, read pipeline, skid buffer, status flags and delivered-word count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            remaining  <= '0;
            inflight   <= 1'b0;
            occ        <= 2'd0;
            head       <= '0;
            tail       <= '0;
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_count_q <= '0;
        end else begin
            if ((state == IDLE) && bus.start) begin
                remaining <= bus.len;
            end else if (rd_en_c) begin
                remaining <= remaining - LEN_W'(1);
            end
            inflight  <= rd_en_c;
            occ       <= occ_nx;
            m_valid_q <= (occ_nx != 2'd0);
            busy_q    <= (state_nx != IDLE);
            done_q    <= (state_nx == DONE);
            if (hs) begin
                rd_count_q <= rd_count_q + CNT_W'(1);
            end
            // Head is always the oldest word; a pop shifts tail forward.
            case ({inflight, hs})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= bus.fifo_dout;
                    end else begin
                        tail <= bus.fifo_dout;
                    end
                end
                2'b01: begin
                    head <= tail;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= bus.fifo_dout;
                    end else begin
                        head <= tail;
                        tail <= bus.fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_en    = rd_en_c;
    assign bus.m_data   = head;
    assign bus.m_valid  = m_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_count = rd_count_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO with one-cycle read
// latency feeds the reader, and a receive log captures every stream handshake.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst;

    fifo_stream_reader_if #(.DATA_W(8), .LEN_W(8), .CNT_W(16)) bus ();

    fifo_stream_reader #(.DATA_W(8), .LEN_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fmem [0:255];
    int         fwr = 0;
    int         frd = 0;
    bit         fifo_inf = 1'b0;
    logic [7:0] fdout = 8'h00;
    int         rd_pulses = 0;
    int         empty_viol = 0;
    logic [7:0] rx [0:255];
    int         rx_n = 0;

    assign bus.empty     = !fifo_inf && (fwr == frd);
    assign bus.fifo_dout = fdout;

    // FIFO model with one-cycle read latency, plus handshake log.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (bus.empty) begin
                empty_viol <= empty_viol + 1;
            end
            if (fifo_inf) begin
                fdout <= 8'hA5;
            end else begin
                fdout <= fmem[frd[7:0]];
                frd   <= frd + 1;
            end
        end
        if (bus.m_valid && bus.m_ready) begin
            rx[rx_n[7:0]] <= bus.m_data;
            rx_n          <= rx_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fmem[fwr[7:0]] = d;
        fwr++;
    endtask

    task automatic start_burst(input logic [7:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.len   = 8'h00;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic chk_rx(input string tag, input int base, input int n, input logic [7:0] first);
        int idx;
        for (int i = 0; i < n; i++) begin
            idx = base + i;
            chk(tag, rx[idx[7:0]], 8'(int'(first) + i));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"},    bus.rd_en,    0);
        chk({tag, "_m_valid"},  bus.m_valid,  0);
        chk({tag, "_m_data"},   bus.m_data,   0);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_done"},     bus.done,     0);
        chk({tag, "_rd_count"}, bus.rd_count, 0);
    endtask

    initial begin
        bit ok;
        int pb;
        int rb;
        int ev;
        int need;
        int l;
        int timeouts;

        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.len     = 8'h00;
        bus.m_ready = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b1;
        tick();

        // Streaming burst of 8 with the consumer always ready.
        for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
        bus.m_ready = 1'b1;
        start_burst(8'd8);
        for (int k = 1; k <= 12; k++) begin
            chk("stream_rd_en", bus.rd_en, (k <= 8));
            chk("stream_valid", bus.m_valid, (k >= 3 && k <= 10));
            if (k >= 3 && k <= 10) chk("stream_data", bus.m_data, 8'(8'h11 * (k - 2)));
            chk("stream_done", bus.done, (k == 11));
            chk("stream_busy", bus.busy, (k <= 11));
            tick();
        end
        chk("stream_count", bus.rd_count, 16'd8);

        // Backpressure: consumer stalled through cycle 9.
        for (int i = 0; i < 5; i++) push(8'(8'h21 + i));
        bus.m_ready = 1'b0;
        pb = rd_pulses;
        rb = rx_n;
        start_burst(8'd5);
        for (int k = 1; k <= 9; k++) begin
            if (k >= 3) begin
                chk("bp_rd_en_stalled", bus.rd_en, 0);
                chk("bp_valid_held", bus.m_valid, 1);
                chk("bp_data_held", bus.m_data, 8'h21);
            end
            tick();
        end
        chk("bp_pulses", rd_pulses - pb, 2);
        bus.m_ready = 1'b1;
        wait_done(50, ok);
        chk("bp_done_seen", ok, 1);
        tick();
        chk("bp_rx_words", rx_n - rb, 5);
        chk_rx("bp_data", rb, 5, 8'h21);
        chk("bp_count", bus.rd_count, 16'd13);

        // Empty stall: only 2 words present, 2 more arrive later.
        push(8'h31);
        push(8'h32);
        ev = empty_viol;
        rb = rx_n;
        start_burst(8'd4);
        for (int k = 1; k <= 5; k++) begin
            if (k >= 3) chk("stall_rd_en", bus.rd_en, 0);
            tick();
        end
        push(8'h33);
        push(8'h34);
        wait_done(40, ok);
        chk("stall_done_seen", ok, 1);
        tick();
        chk("stall_empty_viol", empty_viol - ev, 0);
        chk("stall_rx_words", rx_n - rb, 4);
        chk_rx("stall_data", rb, 4, 8'h31);
        chk("stall_count", bus.rd_count, 16'd17);

        // Zero-length burst.
        pb = rd_pulses;
        start_burst(8'd0);
        chk("len0_done", bus.done, 1);
        chk("len0_busy", bus.busy, 1);
        chk("len0_rd_en", bus.rd_en, 0);
        tick();
        chk("len0_done_clear", bus.done, 0);
        chk("len0_busy_clear", bus.busy, 0);
        chk("len0_pulses", rd_pulses - pb, 0);

        // Start while busy must be ignored.
        for (int i = 0; i < 5; i++) push(8'(8'h41 + i));
        pb = rd_pulses;
        rb = rx_n;
        start_burst(8'd3);
        tick();
        bus.start = 1'b1;
        bus.len   = 8'd7;
        tick();
        bus.start = 1'b0;
        bus.len   = 8'h00;
        wait_done(40, ok);
        chk("busy_start_done_seen", ok, 1);
        tick();
        chk("busy_start_pulses", rd_pulses - pb, 3);
        chk("busy_start_rx_words", rx_n - rb, 3);
        chk_rx("busy_start_data", rb, 3, 8'h41);
        chk("busy_start_fifo_left", fwr - frd, 2);
        chk("busy_start_count", bus.rd_count, 16'd20);
        rb = rx_n;
        start_burst(8'd2);
        wait_done(40, ok);
        chk("leftover_done_seen", ok, 1);
        tick();
        chk_rx("leftover_data", rb, 2, 8'h44);
        chk("leftover_count", bus.rd_count, 16'd22);

        // Reset in the middle of a stalled burst.
        for (int i = 0; i < 8; i++) push(8'(8'h51 + i));
        bus.m_ready = 1'b0;
        start_burst(8'd8);
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk_idle_outputs("midreset");
        rst = 1'b1;
        tick();
        chk("midreset_fifo_left", fwr - frd, 6);
        bus.m_ready = 1'b1;
        rb = rx_n;
        start_burst(8'd6);
        wait_done(40, ok);
        chk("midreset_done_seen", ok, 1);
        tick();
        chk("midreset_rx_words", rx_n - rb, 6);
        chk_rx("midreset_data", rb, 6, 8'h53);
        chk("midreset_count", bus.rd_count, 16'd6);

        // Counter wrap: run the count up to 0xFFFF, then one more word.
        fifo_inf = 1'b1;
        need     = 65535 - 6;
        timeouts = 0;
        while (need > 0) begin
            l = (need > 255) ? 255 : need;
            start_burst(8'(l));
            wait_done(300, ok);
            if (!ok) timeouts++;
            tick();
            need -= l;
        end
        chk("wrap_timeouts", timeouts, 0);
        chk("wrap_count_max", bus.rd_count, 16'hFFFF);
        start_burst(8'd1);
        wait_done(20, ok);
        chk("wrap_last_done_seen", ok, 1);
        tick();
        chk("wrap_count_zero", bus.rd_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side master for the 8-deep, 8-bit synchronous FIFO. On a start command it pops a programmed number of words from the FIFO, honouring `empty` and the FIFO's one-cycle read latency, and presents them on a valid/ready stream toward downstream logic. A 2-entry skid buffer lets it sustain one word per cycle without overrunning a stalled consumer.

## Interface
- DATA_W, 8, FIFO and stream data width
- LEN_W, 8, width of burst length
- CNT_W, 16, width of delivered-word counter

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle burst request; ignored when busy=1
- len  in  LEN_W  words to read; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at burst completion
- empty  in  1  FIFO empty flag
- rd_en  out  1  FIFO pop request
- fifo_dout  in  DATA_W  FIFO read data, valid the cycle after rd_en
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- rd_count  out  CNT_W  words accepted downstream since reset; wraps

## Operation
- State register, states IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE: start=1 latches len into `remaining`. len≠0 → RUN; len=0 → DONE, with no rd_en ever issued.
- RUN: rd_en = !empty && remaining≠0 && credit. Each rd_en decrements remaining. Once the last rd_en issues, go to DRAIN on the next edge.
- credit is true under either condition:
  - occ + inflight ≤ 1, where occ = skid entries (0..2) and inflight = registered rd_en of the previous cycle;
  - occ + inflight = 2 and m_valid && m_ready in the same cycle.
- DRAIN: no rd_en. When occ=0 and inflight=0 → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- busy=1 in RUN, DRAIN and DONE.
- Skid buffer:
  - inflight=1 writes fifo_dout into the tail at the edge.
  - The head drives m_data. m_valid = (occ≠0).
  - A handshake (m_valid && m_ready) pops the head at the edge. Simultaneous write and pop are both applied.
  - Order is strictly FIFO.
- m_data and m_valid are held stable while m_valid=1 and m_ready=0.
- rd_count increments by 1 on every handshake and wraps from 2^CNT_W−1 to 0.
- start during busy is ignored: len is not sampled and the burst is unaffected.
- rd_en is never high while empty=1. The credit rule guarantees occ never exceeds 2.
- Reset mid-burst clears state, skid, inflight and rd_count. A FIFO word popped in the cycle before reset is discarded.

## Timing
- Reset values: rd_en=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0.
- rd_en is combinational from registered state/counters plus empty and m_valid/m_ready. All other outputs are registered.
- start sampled at edge E0 (len≠0, FIFO non-empty): RUN and busy from cycle 1; rd_en in cycle 1; fifo_dout captured at E2; m_valid=1 in cycle 3.
- First-word latency is 3 cycles from start and 2 cycles from rd_en.
- Throughput: with m_ready tied high and FIFO non-empty, rd_en is high every cycle and m_valid is high every cycle after fill.
- m_ready low: at most 2 further rd_en pulses, then rd_en=0 until a handshake.
- len=0: done=1 in cycle 1; busy=1 in cycle 1 only.
- done asserts the cycle after the last word is accepted downstream and no word is in flight.

## Test plan
- **Reset:** drive rst=0 for 2 cycles mid-burst, then release. All outputs read 0 and the FSM is in IDLE; the next start behaves as a fresh burst.
- **Streaming burst:** FIFO preloaded with 0x11..0x88, start with len=8, m_ready=1.
  - rd_en high in cycles 1–8.
  - m_data 0x11..0x88 in order in cycles 3–10.
  - done pulse in cycle 11; rd_count=8.
- **Backpressure:** len=5, m_ready=0 for cycles 0–9, then 1.
  - Exactly 2 rd_en pulses, then rd_en=0 and m_data held at the first word.
  - All 5 words are then delivered in order, with no loss or duplication.
- **Empty stall:** FIFO holds 2 words, start len=4; push 2 more words 6 cycles later.
  - rd_en is never asserted while empty=1.
  - All 4 words are delivered, then done.
- **Edge commands:**
  - start len=0 → done in cycle 1 with no rd_en.
  - start asserted again during busy → ignored, and the burst word count is unchanged.
- **Counter wrap:** preset traffic so rd_count=0xFFFF. The next handshake gives rd_count=0x0000.
